barrel_shifter_pipe: RTL and testbench



---
 rtl/shifter_pkg.sv | 40 ++++
 rtl/barrel_shifter_pipe_if.sv | 31 +++
 rtl/shift_stage.sv | 72 +++++++
 rtl/barrel_shifter_pipe.sv | 66 ++++++
 tb/tb_barrel_shifter_pipe.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter.
//   - Mode encodings for the 3-bit aluc field.
//   - calc_carry(): the last bit shifted/rotated out, taken from the original operand.
package shifter_pkg;

   localparam logic [2:0] SRA     = 3'b000;
   localparam logic [2:0] SLL     = 3'b001;
   localparam logic [2:0] SRL     = 3'b010;
   localparam logic [2:0] SLL_ALT = 3'b011;
   localparam logic [2:0] ROR     = 3'b100;
   localparam logic [2:0] ROL     = 3'b101;

   localparam int unsigned MaxWidth = 64;

   // Operand is zero-extended to MaxWidth; width selects the live portion.
   function automatic logic calc_carry(input logic [MaxWidth-1:0] a,
                                       input int unsigned          n,
                                       input logic [2:0]           aluc,
                                       input int unsigned          width);
      logic [5:0] idx;
      logic       carry;
      idx   = '0;
      carry = 1'b0;
      if (n != 0) begin
         case (aluc)
            SLL, SLL_ALT, ROL: begin
               idx   = 6'(width - n);
               carry = a[idx];
            end
            SRA, SRL, ROR: begin
               idx   = 6'(n - 1);
               carry = a[idx];
            end
            default: carry = 1'b0;
         endcase
      end
      return carry;
   endfunction

endpackage

// File: rtl/barrel_shifter_pipe_if.sv
// Handshake bundle for barrel_shifter_pipe.
//   Upstream  : in_valid, in_ready, a, b, aluc
//   Downstream: out_valid, out_ready, c, carry, zero
//   master = environment side, slave = shifter side.
interface barrel_shifter_pipe_if #(
   parameter int unsigned WIDTH = 32
);
   localparam int unsigned LEVELS = $clog2(WIDTH);

   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  a;
   logic [LEVELS-1:0] b;
   logic [2:0]        aluc;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  c;
   logic              carry;
   logic              zero;

   modport master (
      output in_valid, a, b, aluc, out_ready,
      input  in_ready, out_valid, c, carry, zero
   );

   modport slave (
      input  in_valid, a, b, aluc, out_ready,
      output in_ready, out_valid, c, carry, zero
   );

endinterface

// File: rtl/shift_stage.sv
// One pipeline rank of the barrel shifter: shifts/rotates by 2**K when amt_i[K] is set,
// then registers data with the shift amount, mode, carry and valid under en_i.
//   clk, rst_n : clock, async active-low reset
//   en_i       : global pipeline advance
//   *_i / *_o  : stage input / registered stage output (valid, data, amt, aluc, carry)
module shift_stage
   import shifter_pkg::*;
#(
   parameter  int unsigned WIDTH  = 32,
   parameter  int unsigned K      = 0,
   localparam int unsigned LEVELS = $clog2(WIDTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en_i,
   input  logic              valid_i,
   input  logic [WIDTH-1:0]  data_i,
   input  logic [LEVELS-1:0] amt_i,
   input  logic [2:0]        aluc_i,
   input  logic              carry_i,
   output logic              valid_o,
   output logic [WIDTH-1:0]  data_o,
   output logic [LEVELS-1:0] amt_o,
   output logic [2:0]        aluc_o,
   output logic              carry_o
);

   localparam int unsigned Sh = 2 ** K;

   logic [WIDTH-1:0]  data_d, data_q;
   logic [LEVELS-1:0] amt_q;
   logic [2:0]        aluc_q;
   logic              carry_q;
   logic              valid_q;

   always_comb begin
      data_d = data_i;
      if (amt_i[K]) begin
         case (aluc_i)
            SRA:          data_d = $unsigned($signed(data_i) >>> Sh);
            SLL, SLL_ALT: data_d = data_i << Sh;
            SRL:          data_d = data_i >> Sh;
            ROR:          data_d = (data_i >> Sh) | (data_i << (WIDTH - Sh));
            ROL:          data_d = (data_i << Sh) | (data_i >> (WIDTH - Sh));
            default:      data_d = data_i;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         amt_q   <= '0;
         aluc_q  <= '0;
         carry_q <= 1'b0;
      end else if (en_i) begin
         valid_q <= valid_i;
         data_q  <= data_d;
         amt_q   <= amt_i;
         aluc_q  <= aluc_i;
         carry_q <= carry_i;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign amt_o   = amt_q;
   assign aluc_o  = aluc_q;
   assign carry_o = carry_q;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter with SRA/SLL/SRL/ROR/ROL, carry-out and zero flag.
// LEVELS = log2(WIDTH) ranks, one per shift-amount bit; latency LEVELS, one result/cycle.
//   clk, rst_n : clock, async active-low reset
//   bus        : valid/ready operand input and result output (slave side)
// Back-pressure is a single global enable; bubbles are not collapsed.
module barrel_shifter_pipe
   import shifter_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input logic                  clk,
   input logic                  rst_n,
   barrel_shifter_pipe_if.slave bus
);

   localparam int unsigned LEVELS = $clog2(WIDTH);

   logic              en;
   logic              valid_s [LEVELS+1];
   logic [WIDTH-1:0]  data_s  [LEVELS+1];
   logic [LEVELS-1:0] amt_s   [LEVELS+1];
   logic [2:0]        aluc_s  [LEVELS+1];
   logic              carry_s [LEVELS+1];
   logic              unused_tail;

   // Whole pipe moves whenever the output slot is empty or being drained.
   assign en           = bus.out_ready || !bus.out_valid;
   assign bus.in_ready = en;

   // Carry comes from the unshifted operand, so it is resolved before the first rank.
   assign valid_s[0] = bus.in_valid;
   assign data_s[0]  = bus.a;
   assign amt_s[0]   = bus.b;
   assign aluc_s[0]  = bus.aluc;
   assign carry_s[0] = calc_carry(64'(bus.a), 32'(bus.b), bus.aluc, WIDTH);

   for (genvar k = 0; k < LEVELS; k++) begin : g_stage
      shift_stage #(
         .WIDTH (WIDTH),
         .K     (k)
      ) u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .en_i    (en),
         .valid_i (valid_s[k]),
         .data_i  (data_s[k]),
         .amt_i   (amt_s[k]),
         .aluc_i  (aluc_s[k]),
         .carry_i (carry_s[k]),
         .valid_o (valid_s[k+1]),
         .data_o  (data_s[k+1]),
         .amt_o   (amt_s[k+1]),
         .aluc_o  (aluc_s[k+1]),
         .carry_o (carry_s[k+1])
      );
   end

   assign bus.out_valid = valid_s[LEVELS];
   assign bus.c         = data_s[LEVELS];
   assign bus.carry     = carry_s[LEVELS];
   assign bus.zero      = (data_s[LEVELS] == '0);

   // Amount and mode are no longer needed after the last rank.
   assign unused_tail = ^{amt_s[LEVELS], aluc_s[LEVELS]};

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
module tb_barrel_shifter_pipe;
   import shifter_pkg::*;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   barrel_shifter_pipe_if #(.WIDTH(32)) if32 ();
   barrel_shifter_pipe_if #(.WIDTH(8))  if8 ();

   barrel_shifter_pipe #(.WIDTH(32)) u_dut32 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if32)
   );

   barrel_shifter_pipe #(.WIDTH(8)) u_dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1);
   end

   // Issue one op on the 32-bit instance and wait for its result (bounded).
   task automatic run_op32(input logic [31:0] a, input logic [4:0] b, input logic [2:0] m,
                           output logic [31:0] c, output logic cy, output logic z,
                           output int lat);
      @(negedge clk);
      if32.a = a; if32.b = b; if32.aluc = m; if32.in_valid = 1'b1; if32.out_ready = 1'b1;
      @(posedge clk);
      #1 if32.in_valid = 1'b0;
      lat = 99; c = 'x; cy = 1'bx; z = 1'bx;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (if32.out_valid) begin
            lat = i; c = if32.c; cy = if32.carry; z = if32.zero;
            break;
         end
      end
   endtask

   task automatic run_op8(input logic [7:0] a, input logic [2:0] b, input logic [2:0] m,
                          output logic [7:0] c, output logic cy, output int lat);
      @(negedge clk);
      if8.a = a; if8.b = b; if8.aluc = m; if8.in_valid = 1'b1; if8.out_ready = 1'b1;
      @(posedge clk);
      #1 if8.in_valid = 1'b0;
      lat = 99; c = 'x; cy = 1'bx;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (if8.out_valid) begin
            lat = i; c = if8.c; cy = if8.carry;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #1;
      n_cmp++; if (if32.out_valid !== 1'b0) begin n_err++;
         $display("FAIL reset_out_valid: got %b required 0", if32.out_valid); end
      n_cmp++; if (if32.c !== 32'h0) begin n_err++;
         $display("FAIL reset_c: got %h required 00000000", if32.c); end
      n_cmp++; if (if32.zero !== 1'b1) begin n_err++;
         $display("FAIL reset_zero: got %b required 1", if32.zero); end
      n_cmp++; if (if32.carry !== 1'b0) begin n_err++;
         $display("FAIL reset_carry: got %b required 0", if32.carry); end
      n_cmp++; if (if8.out_valid !== 1'b0) begin n_err++;
         $display("FAIL reset_out_valid8: got %b required 0", if8.out_valid); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_cmp++; if (if32.in_ready !== 1'b1) begin n_err++;
         $display("FAIL reset_in_ready: got %b required 1", if32.in_ready); end
      n_cmp++; if (if8.in_ready !== 1'b1) begin n_err++;
         $display("FAIL reset_in_ready8: got %b required 1", if8.in_ready); end
   endtask

   task automatic test_shift_right();
      logic [31:0] c; logic cy, z; int lat;
      run_op32(32'h8000_0001, 5'd4, SRA, c, cy, z, lat);
      n_cmp++; if (c !== 32'hF800_0000) begin n_err++;
         $display("FAIL sra4_c: got %h required f8000000", c); end
      n_cmp++; if (cy !== 1'b0) begin n_err++; $display("FAIL sra4_carry: got %b required 0", cy); end
      n_cmp++; if (z !== 1'b0) begin n_err++; $display("FAIL sra4_zero: got %b required 0", z); end
      n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL sra4_latency: got %0d required 5", lat); end
      run_op32(32'h8000_0000, 5'd31, SRA, c, cy, z, lat);
      n_cmp++; if (c !== 32'hFFFF_FFFF) begin n_err++;
         $display("FAIL sra31_c: got %h required ffffffff", c); end
      n_cmp++; if (cy !== 1'b0) begin n_err++; $display("FAIL sra31_carry: got %b required 0", cy); end
      run_op32(32'h0000_00F8, 5'd4, SRL, c, cy, z, lat);
      n_cmp++; if (c !== 32'h0000_000F) begin n_err++;
         $display("FAIL srl4_c: got %h required 0000000f", c); end
      n_cmp++; if (cy !== 1'b1) begin n_err++; $display("FAIL srl4_carry: got %b required 1", cy); end
   endtask

   task automatic test_rotate();
      logic [31:0] c; logic cy, z; int lat;
      run_op32(32'h8000_0001, 5'd1, ROR, c, cy, z, lat);
      n_cmp++; if (c !== 32'hC000_0000) begin n_err++;
         $display("FAIL ror1_c: got %h required c0000000", c); end
      n_cmp++; if (cy !== 1'b1) begin n_err++; $display("FAIL ror1_carry: got %b required 1", cy); end
      // Last bit out of ROL by 31 is a[1].
      run_op32(32'h8000_0001, 5'd31, ROL, c, cy, z, lat);
      n_cmp++; if (c !== 32'hC000_0000) begin n_err++;
         $display("FAIL rol31_c: got %h required c0000000", c); end
      n_cmp++; if (cy !== 1'b0) begin n_err++; $display("FAIL rol31_carry: got %b required 0", cy); end
      run_op32(32'h1234_5678, 5'd8, ROR, c, cy, z, lat);
      n_cmp++; if (c !== 32'h7812_3456) begin n_err++;
         $display("FAIL ror8_c: got %h required 78123456", c); end
      run_op32(32'h1234_5678, 5'd24, ROL, c, cy, z, lat);
      n_cmp++; if (c !== 32'h7812_3456) begin n_err++;
         $display("FAIL rol24_c: got %h required 78123456", c); end
   endtask

   task automatic test_shift_left();
      logic [31:0] c; logic cy, z; int lat;
      // Last bit out of SLL by 31 is a[1], which is 0 for 0xF0.
      run_op32(32'h0000_00F0, 5'd31, SLL, c, cy, z, lat);
      n_cmp++; if (c !== 32'h0) begin n_err++; $display("FAIL sll31_c: got %h required 00000000", c); end
      n_cmp++; if (z !== 1'b1) begin n_err++; $display("FAIL sll31_zero: got %b required 1", z); end
      n_cmp++; if (cy !== 1'b0) begin n_err++; $display("FAIL sll31_carry: got %b required 0", cy); end
      run_op32(32'h0000_00F0, 5'd28, SLL_ALT, c, cy, z, lat);
      n_cmp++; if (c !== 32'h0) begin n_err++; $display("FAIL sll28_c: got %h required 00000000", c); end
      n_cmp++; if (cy !== 1'b1) begin n_err++; $display("FAIL sll28_carry: got %b required 1", cy); end
      n_cmp++; if (z !== 1'b1) begin n_err++; $display("FAIL sll28_zero: got %b required 1", z); end
      run_op32(32'h0000_00F0, 5'd4, SLL, c, cy, z, lat);
      n_cmp++; if (c !== 32'h0000_0F00) begin n_err++;
         $display("FAIL sll4_c: got %h required 00000f00", c); end
      n_cmp++; if (z !== 1'b0) begin n_err++; $display("FAIL sll4_zero: got %b required 0", z); end
   endtask

   task automatic test_b_zero_and_reserved();
      logic [31:0] c; logic cy, z; int lat;
      for (int m = 0; m < 8; m++) begin
         run_op32(32'h1234_5678, 5'd0, 3'(m), c, cy, z, lat);
         n_cmp++; if (c !== 32'h1234_5678) begin n_err++;
            $display("FAIL b0_c mode %0d: got %h required 12345678", m, c); end
         n_cmp++; if (cy !== 1'b0) begin n_err++;
            $display("FAIL b0_carry mode %0d: got %b required 0", m, cy); end
      end
      run_op32(32'hA5A5_0F0F, 5'd5, 3'b110, c, cy, z, lat);
      n_cmp++; if (c !== 32'hA5A5_0F0F) begin n_err++;
         $display("FAIL reserved_c: got %h required a5a50f0f", c); end
      n_cmp++; if (cy !== 1'b0) begin n_err++; $display("FAIL reserved_carry: got %b required 0", cy); end
   endtask

   task automatic test_width8();
      logic [7:0] c; logic cy; int lat;
      run_op8(8'h96, 3'd3, SRL, c, cy, lat);
      n_cmp++; if (c !== 8'h12) begin n_err++; $display("FAIL w8_srl3_c: got %h required 12", c); end
      n_cmp++; if (cy !== 1'b1) begin n_err++; $display("FAIL w8_srl3_carry: got %b required 1", cy); end
      n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL w8_latency: got %0d required 3", lat); end
      run_op8(8'h96, 3'd7, SRA, c, cy, lat);
      n_cmp++; if (c !== 8'hFF) begin n_err++; $display("FAIL w8_sra7_c: got %h required ff", c); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_q [8];
      logic        exp_rdy;
      int          snd, rcv, extra;
      for (int i = 0; i < 8; i++) exp_q[i] = (32'h100 + 32'(i)) << i;
      snd = 0; rcv = 0;
      for (int cyc = 0; cyc < 40 && rcv < 8; cyc++) begin
         @(negedge clk);
         exp_rdy = !(cyc >= 6 && cyc <= 9);
         if32.out_ready = exp_rdy;
         if (snd < 8) begin
            if32.in_valid = 1'b1; if32.a = 32'h100 + 32'(snd); if32.b = 5'(snd); if32.aluc = SLL;
         end else begin
            if32.in_valid = 1'b0;
         end
         #1;
         n_cmp++; if (if32.in_ready !== exp_rdy) begin n_err++;
            $display("FAIL b2b_in_ready cyc %0d: got %b required %b", cyc, if32.in_ready, exp_rdy); end
         if (if32.out_valid) begin
            n_cmp++; if (if32.c !== exp_q[rcv]) begin n_err++;
               $display("FAIL b2b_c idx %0d cyc %0d: got %h required %h", rcv, cyc, if32.c, exp_q[rcv]);
            end
            if (exp_rdy) rcv++;
         end
         if (if32.in_valid && exp_rdy) snd++;
      end
      n_cmp++; if (rcv !== 8) begin n_err++; $display("FAIL b2b_count: got %0d required 8", rcv); end
      if32.in_valid = 1'b0;
      extra = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (if32.out_valid) extra++;
      end
      n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL b2b_extra: got %0d required 0", extra); end
   endtask

   task automatic test_reset_inflight();
      logic [31:0] c; logic cy, z; int lat, stale;
      if32.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if32.in_valid = 1'b1; if32.a = 32'hFFFF_FFFF; if32.b = 5'd0; if32.aluc = SLL;
      end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (if32.out_valid !== 1'b0) begin n_err++;
         $display("FAIL rst_mid_out_valid: got %b required 0", if32.out_valid); end
      n_cmp++; if (if32.c !== 32'h0) begin n_err++;
         $display("FAIL rst_mid_c: got %h required 00000000", if32.c); end
      n_cmp++; if (if32.zero !== 1'b1) begin n_err++;
         $display("FAIL rst_mid_zero: got %b required 1", if32.zero); end
      if32.in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      stale = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (if32.out_valid) stale++;
      end
      n_cmp++; if (stale !== 0) begin n_err++; $display("FAIL rst_mid_stale: got %0d required 0", stale); end
      run_op32(32'h0000_0003, 5'd2, SLL, c, cy, z, lat);
      n_cmp++; if (c !== 32'h0000_000C) begin n_err++;
         $display("FAIL rst_after_c: got %h required 0000000c", c); end
      n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL rst_after_latency: got %0d required 5", lat); end
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      rst_n = 1'b0;
      if32.in_valid = 1'b0; if32.a = '0; if32.b = '0; if32.aluc = '0; if32.out_ready = 1'b1;
      if8.in_valid = 1'b0;  if8.a = '0;  if8.b = '0;  if8.aluc = '0;  if8.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      test_reset();
      test_shift_right();
      test_rotate();
      test_shift_left();
      test_b_zero_and_reserved();
      test_width8();
      test_back_to_back();
      test_reset_inflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
